// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file debug dump path.
//   DATA_W   : register data width
//   ADDR_W   : register index width
//   NUM_REGS : number of architectural registers
//   state_t  : dump engine FSM states
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks a contiguous register range through a dedicated
// register-file read port and streams each value, tagged with its index, over a
// valid/ready interface. The pipeline is held off (hold_req) while the walk runs.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   start                 dump request (sampled in IDLE only)
//   first_reg, last_reg   inclusive register range, sampled with start
//   rd_addr, rd_data      register-file read port (rd_data is combinational)
//   out_valid, out_ready  stream handshake
//   out_data, out_index   register value and its index
//   out_last              final word of the dump
//   busy, hold_req        engine active / suppress pipeline register writes
//   done, err             one-cycle pulses: dump complete / range rejected
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              hold_req,
  output logic              done,
  output logic              err
);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] last_q;
  // Accepted request waiting one cycle in IDLE, so hold_req is raised a full
  // cycle before the first capture and the pipeline has a negedge to honour it.
  logic              pend_q;

  assign rd_addr  = idx_q;
  assign hold_req = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      pend_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pend_q) begin
            pend_q  <= 1'b0;
            busy    <= 1'b1;
            state_q <= READ;
          end else if (start) begin
            if (first_reg <= last_reg) begin
              idx_q  <= first_reg;
              last_q <= last_reg;
              pend_q <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_index <= idx_q;
          out_last  <= (idx_q == last_q);
          out_valid <= 1'b1;
          state_q   <= SEND;
        end
        SEND: begin
          // out_valid is always 1 here, so out_ready alone completes the handshake.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= DONE;
            end else begin
              // No wrap possible: only reached while idx_q < last_q.
              idx_q   <= idx_q + ADDR_W'(1);
              state_q <= READ;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader. A behavioural register file and a
// write-issuing pipeline model surround the DUT; a negedge monitor records every
// accepted word and pulse, and each test task compares the recording with the
// words expected from a snapshot of the register contents.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] first_reg = '0;
  logic [ADDR_W-1:0] last_reg = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              busy;
  logic              hold_req;
  logic              done;
  logic              err;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_dump_reader u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .hold_req  (hold_req),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Register file model: register 0 reads 0, writes land on negedge.
  logic [DATA_W-1:0] rf       [NUM_REGS];
  logic [DATA_W-1:0] load_img [NUM_REGS];
  logic [DATA_W-1:0] snap     [NUM_REGS];
  logic              load_req = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  int                wr_mode = 0;
  int                wr_lo = 0;
  int                wr_hi = 31;
  int                rdy_mode = 0;  // 0: low, 1: high, 2: random

  assign rd_data = (rd_addr == '0) ? '0 : rf[rd_addr];

  always @(negedge clk) begin
    if (load_req) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= load_img[i];
    end else if (wr_en && !hold_req) begin
      rf[wr_addr] <= wr_data;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    wr_en   = (wr_mode != 0) && ($urandom_range(0, 3) != 0);
    wr_addr = ADDR_W'($urandom_range(wr_lo, wr_hi));
    wr_data = $urandom;
  end

  // Monitor
  logic [ADDR_W-1:0] got_idx [$];
  logic [DATA_W-1:0] got_data [$];
  logic              got_last [$];
  int busy_rise [$];
  int valid_rise [$];
  int done_edge [$];
  int err_edge [$];
  int stall_viol = 0;
  int hold_viol = 0;
  int both_cnt = 0;
  int busy_cyc = 0;
  logic              p_valid = 1'b0, p_ready = 1'b0, p_busy = 1'b0, p_last = 1'b0;
  logic [DATA_W-1:0] p_data = '0;
  logic [ADDR_W-1:0] p_index = '0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_idx.push_back(out_index);
      got_data.push_back(out_data);
      got_last.push_back(out_last);
    end
    if (busy && !p_busy) busy_rise.push_back(edge_cnt);
    if (out_valid && !p_valid) valid_rise.push_back(edge_cnt);
    if (done) done_edge.push_back(edge_cnt);
    if (err) err_edge.push_back(edge_cnt);
    if (done && err) both_cnt <= both_cnt + 1;
    if (hold_req !== busy) hold_viol <= hold_viol + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (p_valid && !p_ready && rst &&
        (!out_valid || out_data !== p_data || out_index !== p_index || out_last !== p_last))
      stall_viol <= stall_viol + 1;
    p_valid <= out_valid;
    p_ready <= out_ready;
    p_busy  <= busy;
    p_data  <= out_data;
    p_index <= out_index;
    p_last  <= out_last;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_image();
    load_req = 1'b1;
    @(negedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic random_image();
    for (int i = 0; i < NUM_REGS; i++) load_img[i] = $urandom;
    load_image();
    snap = load_img;
  endtask

  // Returns the edge number at which start was sampled.
  task automatic start_dump(input int f, input int l, output int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    @(posedge clk);
    #1;
    n     = edge_cnt;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      #1;
      if (done_edge.size() > base) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, out_last, busy, hold_req, done, err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000000",
               {out_valid, out_last, busy, hold_req, done, err});
    end
    n_cmp++;
    if (out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", out_data);
    end
    n_cmp++;
    if (out_index !== '0 || rd_addr !== '0) begin
      n_bad++;
      $display("FAIL reset_index got idx=%0d rd_addr=%0d want 0/0", out_index, rd_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset got busy=%b valid=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_full_dump();
    int n, bw, bd, bb, bv;
    bit ok;
    for (int i = 0; i < NUM_REGS; i++) load_img[i] = 32'h1000 + i;
    load_image();
    wr_mode = 0;
    rdy_mode = 1;
    bw = got_idx.size(); bd = done_edge.size(); bb = busy_rise.size(); bv = valid_rise.size();
    start_dump(0, 31, n);
    wait_done(bd, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL full_done_timeout got no done want done");
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (got_idx.size() - bw != 32) begin
      n_bad++;
      $display("FAIL full_count got %0d want 32", got_idx.size() - bw);
    end
    for (int k = 0; k < 32 && bw + k < got_idx.size(); k++) begin
      n_cmp++;
      if (got_idx[bw+k] !== ADDR_W'(k) || got_data[bw+k] !== ((k == 0) ? 32'h0 : 32'h1000 + k)
          || got_last[bw+k] !== (k == 31)) begin
        n_bad++;
        $display("FAIL full_word%0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 k, got_idx[bw+k], got_data[bw+k], got_last[bw+k], k,
                 (k == 0) ? 32'h0 : 32'h1000 + k, k == 31);
      end
    end
    n_cmp++;
    if (busy_rise.size() <= bb || busy_rise[bb] != n + 1) begin
      n_bad++;
      $display("FAIL full_hold_rise got %0d want %0d",
               (busy_rise.size() > bb) ? busy_rise[bb] : -1, n + 1);
    end
    n_cmp++;
    if (valid_rise.size() <= bv || valid_rise[bv] != n + 2) begin
      n_bad++;
      $display("FAIL full_first_valid got %0d want %0d",
               (valid_rise.size() > bv) ? valid_rise[bv] : -1, n + 2);
    end
    n_cmp++;
    if (done_edge.size() != bd + 1 || done_edge[bd] != n + 65) begin
      n_bad++;
      $display("FAIL full_done_edge got %0d (count %0d) want %0d (count 1)",
               (done_edge.size() > bd) ? done_edge[bd] : -1, done_edge.size() - bd, n + 65);
    end
  endtask

  task automatic test_backpressure();
    int n, bw, bd, bs;
    bit ok;
    random_image();
    rdy_mode = 2;
    bw = got_idx.size(); bd = done_edge.size(); bs = stall_viol;
    start_dump(3, 5, n);
    wait_done(bd, 300, ok);
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || got_idx.size() - bw != 3) begin
      n_bad++;
      $display("FAIL bp_count got %0d words done=%b want 3 words done=1", got_idx.size() - bw, ok);
    end
    for (int k = 0; k < 3 && bw + k < got_idx.size(); k++) begin
      n_cmp++;
      if (got_idx[bw+k] !== ADDR_W'(3 + k) || got_data[bw+k] !== snap[3+k]
          || got_last[bw+k] !== (k == 2)) begin
        n_bad++;
        $display("FAIL bp_word%0d got idx=%0d data=%h last=%b want idx=%0d data=%h last=%b",
                 k, got_idx[bw+k], got_data[bw+k], got_last[bw+k], 3 + k, snap[3+k], k == 2);
      end
    end
    n_cmp++;
    if (stall_viol != bs) begin
      n_bad++;
      $display("FAIL bp_stable got %0d changes while stalled want 0", stall_viol - bs);
    end
  endtask

  task automatic test_single_and_error();
    int n, bw, bd, be, bv, bb, bc;
    bit ok;
    random_image();
    rdy_mode = 1;
    bw = got_idx.size(); bd = done_edge.size();
    start_dump(7, 7, n);
    wait_done(bd, 50, ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || got_idx.size() - bw != 1 || got_idx[bw] !== 5'd7 || got_data[bw] !== snap[7]
        || got_last[bw] !== 1'b1) begin
      n_bad++;
      $display("FAIL single_word got %0d words done=%b want one word idx 7 data %h last 1",
               got_idx.size() - bw, ok, snap[7]);
    end
    n_cmp++;
    if (done_edge.size() <= bd || done_edge[bd] != n + 3) begin
      n_bad++;
      $display("FAIL single_done_edge got %0d want %0d",
               (done_edge.size() > bd) ? done_edge[bd] : -1, n + 3);
    end
    be = err_edge.size(); bv = valid_rise.size(); bb = busy_rise.size(); bc = busy_cyc;
    bd = done_edge.size();
    start_dump(9, 4, n);
    repeat (6) @(negedge clk);
    #1;
    n_cmp++;
    if (err_edge.size() - be != 1 || err_edge[be] != n) begin
      n_bad++;
      $display("FAIL err_pulse got %0d cycles first %0d want 1 cycle at %0d",
               err_edge.size() - be, (err_edge.size() > be) ? err_edge[be] : -1, n);
    end
    n_cmp++;
    if (valid_rise.size() != bv || busy_rise.size() != bb || busy_cyc != bc
        || done_edge.size() != bd) begin
      n_bad++;
      $display("FAIL err_quiet got valid=%0d busy=%0d done=%0d want 0/0/0",
               valid_rise.size() - bv, busy_cyc - bc, done_edge.size() - bd);
    end
  endtask

  task automatic test_start_while_busy();
    int n, bw, bd, bb;
    bit ok;
    random_image();
    rdy_mode = 1;
    bw = got_idx.size(); bd = done_edge.size(); bb = busy_rise.size();
    start_dump(0, 3, n);
    start = 1'b1;
    first_reg = 5'd10;
    last_reg = 5'd20;
    repeat (4) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(bd, 100, ok);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (!ok || got_idx.size() - bw != 4 || done_edge.size() - bd != 1
        || busy_rise.size() - bb != 1) begin
      n_bad++;
      $display("FAIL busy_start got words=%0d done=%0d runs=%0d want 4/1/1",
               got_idx.size() - bw, done_edge.size() - bd, busy_rise.size() - bb);
    end
    for (int k = 0; k < 4 && bw + k < got_idx.size(); k++) begin
      n_cmp++;
      if (got_idx[bw+k] !== ADDR_W'(k) || got_data[bw+k] !== ((k == 0) ? 32'h0 : snap[k])) begin
        n_bad++;
        $display("FAIL busy_word%0d got idx=%0d data=%h want idx=%0d data=%h", k,
                 got_idx[bw+k], got_data[bw+k], k, (k == 0) ? 32'h0 : snap[k]);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int n, bw, bd, bb;
    bit ok, found;
    random_image();
    rdy_mode = 1;
    bw = got_idx.size(); bd = done_edge.size();
    start_dump(0, 31, n);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_index == 5'd10) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL rstmid_reach got no word 10 want word 10");
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_last, busy, hold_req, done, err} !== 6'b0 || out_data !== '0
        || out_index !== '0 || rd_addr !== '0) begin
      n_bad++;
      $display("FAIL rstmid_clear got flags=%b data=%h idx=%0d rd=%0d want all 0",
               {out_valid, out_last, busy, hold_req, done, err}, out_data, out_index, rd_addr);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    n_cmp++;
    if (got_idx.size() - bw != 10 || done_edge.size() != bd || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_abort got words=%0d done=%0d busy=%b want 10/0/0",
               got_idx.size() - bw, done_edge.size() - bd, busy);
    end
    bw = got_idx.size(); bd = done_edge.size(); bb = busy_rise.size();
    start_dump(2, 6, n);
    wait_done(bd, 100, ok);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (!ok || got_idx.size() - bw != 5) begin
      n_bad++;
      $display("FAIL rstmid_redump got %0d words done=%b want 5 words done=1",
               got_idx.size() - bw, ok);
    end
    for (int k = 0; k < 5 && bw + k < got_idx.size(); k++) begin
      n_cmp++;
      if (got_idx[bw+k] !== ADDR_W'(2 + k) || got_data[bw+k] !== snap[2+k]
          || got_last[bw+k] !== (k == 4)) begin
        n_bad++;
        $display("FAIL rstmid_word%0d got idx=%0d data=%h want idx=%0d data=%h", k,
                 got_idx[bw+k], got_data[bw+k], 2 + k, snap[2+k]);
      end
    end
  endtask

  task automatic test_hold();
    int n, bw, bd, f, l;
    bit ok;
    for (int it = 0; it < 3; it++) begin
      random_image();
      f = $urandom_range(0, 24);
      l = f + $urandom_range(0, 7);
      wr_lo = f;
      wr_hi = l;
      wr_mode = 1;
      rdy_mode = 2;
      bw = got_idx.size(); bd = done_edge.size();
      start_dump(f, l, n);
      @(posedge clk);
      #1;
      n_cmp++;
      if (hold_req !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_rise%0d got %b want 1", it, hold_req);
      end
      snap = rf;
      wait_done(bd, 400, ok);
      wr_mode = 0;
      rdy_mode = 1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (!ok || got_idx.size() - bw != l - f + 1) begin
        n_bad++;
        $display("FAIL hold_count%0d got %0d done=%b want %0d", it, got_idx.size() - bw, ok,
                 l - f + 1);
      end
      for (int k = 0; k <= l - f && bw + k < got_idx.size(); k++) begin
        n_cmp++;
        if (got_idx[bw+k] !== ADDR_W'(f + k)
            || got_data[bw+k] !== ((f + k == 0) ? 32'h0 : snap[f+k])
            || got_last[bw+k] !== (f + k == l)) begin
          n_bad++;
          $display("FAIL hold_word%0d_%0d got idx=%0d data=%h want idx=%0d data=%h", it, k,
                   got_idx[bw+k], got_data[bw+k], f + k, (f + k == 0) ? 32'h0 : snap[f+k]);
        end
      end
    end
    wr_lo = 0;
    wr_hi = 31;
  endtask

  initial begin
    test_reset();
    test_full_dump();
    test_backpressure();
    test_single_and_error();
    test_start_while_busy();
    test_reset_mid_dump();
    test_hold();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (hold_viol != 0 || both_cnt != 0) begin
      n_bad++;
      $display("FAIL global_pulses got hold/busy diffs=%0d done&err=%0d want 0/0",
               hold_viol, both_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
